// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle controller and the shared MIPS datapath.
// master = controller side, slave = datapath/memory side.
interface multicycle_ctrl_if;
  logic [5:0] instr_op_i;
  logic       mem_ack_i;
  logic       mem_req_o;
  logic       IorD_o;
  logic       MemRead_o;
  logic       MemWrite_o;
  logic       IRWrite_o;
  logic       PCWrite_o;
  logic       PCWriteCond_o;
  logic       BranchNE_o;
  logic [1:0] PCSource_o;
  logic       ALUSrcA_o;
  logic [1:0] ALUSrcB_o;
  logic [2:0] ALU_op_o;
  logic       RegDst_o;
  logic       MemtoReg_o;
  logic       RegWrite_o;
  logic       instr_done_o;
  logic       fault_o;
  logic [1:0] fault_code_o;
  logic [3:0] state_o;

  modport master (
    input  instr_op_i, mem_ack_i,
    output mem_req_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o, PCWrite_o,
           PCWriteCond_o, BranchNE_o, PCSource_o, ALUSrcA_o, ALUSrcB_o, ALU_op_o,
           RegDst_o, MemtoReg_o, RegWrite_o, instr_done_o, fault_o, fault_code_o,
           state_o
  );

  modport slave (
    output instr_op_i, mem_ack_i,
    input  mem_req_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o, PCWrite_o,
           PCWriteCond_o, BranchNE_o, PCSource_o, ALUSrcA_o, ALUSrcB_o, ALU_op_o,
           RegDst_o, MemtoReg_o, RegWrite_o, instr_done_o, fault_o, fault_code_o,
           state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EX/MEM/WB over a shared datapath,
// with a timed request/ack memory handshake and a sticky fault state.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  multicycle_ctrl_if.master bus
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_IF       = 4'd0,
    S_ID       = 4'd1,
    S_EX_R     = 4'd2,
    S_EX_I     = 4'd3,
    S_EX_BR    = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_R     = 4'd8,
    S_WB_I     = 4'd9,
    S_WB_LW    = 4'd10,
    S_FAULT    = 4'd11
  } state_t;

  state_t          state, nxt_state;
  logic [CW-1:0]   wait_cnt;
  logic [1:0]      fault_code, nxt_code;
  logic            wait_last;
  logic            in_wait_state;

  logic       mem_req, iord, mem_read, mem_write, ir_write, pc_write, pc_write_cond;
  logic       branch_ne, alu_src_a, reg_dst, mem_to_reg, reg_write, instr_done;
  logic [1:0] pc_source, alu_src_b;
  logic [2:0] alu_op;

  assign in_wait_state = (state == S_IF) || (state == S_MEM_RD) || (state == S_MEM_WR);
  // Last permitted cycle of a memory wait; an ack here still takes the normal path.
  assign wait_last     = (wait_cnt == WAIT_LAST);

  always_comb begin
    nxt_state     = state;
    nxt_code      = 2'b00;
    mem_req       = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_source     = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    instr_done    = 1'b0;
    case (state)
      S_IF: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        if (bus.mem_ack_i) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
          nxt_state = S_ID;
        end else if (wait_last) begin
          nxt_state = S_FAULT;
          nxt_code  = 2'b10;
        end
      end
      S_ID: begin
        alu_src_b = 2'b11;
        case (bus.instr_op_i)
          OP_RTYPE:                         nxt_state = S_EX_R;
          OP_ADDI, OP_SLTI, OP_LUI, OP_ORI: nxt_state = S_EX_I;
          OP_BEQ, OP_BNE:                   nxt_state = S_EX_BR;
          OP_LW, OP_SW:                     nxt_state = S_MEM_ADDR;
          default: begin
            nxt_state = S_FAULT;
            nxt_code  = 2'b01;
          end
        endcase
      end
      S_EX_R: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b100;
        nxt_state = S_WB_R;
      end
      S_EX_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (bus.instr_op_i)
          OP_SLTI: alu_op = 3'b100;
          OP_LUI:  alu_op = 3'b010;
          OP_ORI:  alu_op = 3'b011;
          default: alu_op = 3'b000;
        endcase
        nxt_state = S_WB_I;
      end
      S_EX_BR: begin
        alu_src_a     = 1'b1;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        branch_ne     = (bus.instr_op_i == OP_BNE);
        alu_op        = branch_ne ? 3'b101 : 3'b001;
        instr_done    = 1'b1;
        nxt_state     = S_IF;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (bus.instr_op_i == OP_LW) begin
          nxt_state = S_MEM_RD;
        end else if (bus.instr_op_i == OP_SW) begin
          nxt_state = S_MEM_WR;
        end else begin
          nxt_state = S_FAULT;
          nxt_code  = 2'b01;
        end
      end
      S_MEM_RD: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        iord     = 1'b1;
        if (bus.mem_ack_i) begin
          nxt_state = S_WB_LW;
        end else if (wait_last) begin
          nxt_state = S_FAULT;
          nxt_code  = 2'b10;
        end
      end
      S_MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        if (bus.mem_ack_i) begin
          instr_done = 1'b1;
          nxt_state  = S_IF;
        end else if (wait_last) begin
          nxt_state = S_FAULT;
          nxt_code  = 2'b10;
        end
      end
      S_WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        nxt_state  = S_IF;
      end
      S_WB_I: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        nxt_state  = S_IF;
      end
      S_WB_LW: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        nxt_state  = S_IF;
      end
      S_FAULT:  nxt_state = S_FAULT;
      default:  nxt_state = S_IF;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IF;
      wait_cnt   <= '0;
      fault_code <= 2'b00;
    end else begin
      state <= nxt_state;
      // Staying in a wait state means no ack this cycle; any transition restarts the count.
      if (in_wait_state && (nxt_state == state)) begin
        wait_cnt <= wait_cnt + CW'(1);
      end else begin
        wait_cnt <= '0;
      end
      if ((nxt_state == S_FAULT) && (state != S_FAULT)) begin
        fault_code <= nxt_code;
      end
    end
  end

  // Gating by rst_i keeps every strobe low for the whole reset window,
  // so no partial PC/register write can slip out mid-instruction.
  assign bus.mem_req_o     = mem_req & ~rst_i;
  assign bus.IorD_o        = iord & ~rst_i;
  assign bus.MemRead_o     = mem_read & ~rst_i;
  assign bus.MemWrite_o    = mem_write & ~rst_i;
  assign bus.IRWrite_o     = ir_write & ~rst_i;
  assign bus.PCWrite_o     = pc_write & ~rst_i;
  assign bus.PCWriteCond_o = pc_write_cond & ~rst_i;
  assign bus.BranchNE_o    = branch_ne & ~rst_i;
  assign bus.PCSource_o    = rst_i ? '0 : pc_source;
  assign bus.ALUSrcA_o     = alu_src_a & ~rst_i;
  assign bus.ALUSrcB_o     = rst_i ? '0 : alu_src_b;
  assign bus.ALU_op_o      = rst_i ? '0 : alu_op;
  assign bus.RegDst_o      = reg_dst & ~rst_i;
  assign bus.MemtoReg_o    = mem_to_reg & ~rst_i;
  assign bus.RegWrite_o    = reg_write & ~rst_i;
  assign bus.instr_done_o  = instr_done & ~rst_i;
  assign bus.fault_o       = (state == S_FAULT) & ~rst_i;
  assign bus.fault_code_o  = rst_i ? '0 : fault_code;
  assign bus.state_o       = rst_i ? '0 : state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (MEM_TIMEOUT=4); each task walks one
// instruction cycle by cycle against hand-written state/control expectations.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       mem_req;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       BranchNE;
    logic [1:0] PCSource;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALU_op;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       instr_done;
    logic       fault;
    logic [1:0] fault_code;
  } ctrl_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  int unsigned checks = 0;
  int unsigned fails  = 0;
  ctrl_t       obs;
  ctrl_t       E_IF_WAIT, E_IF_ACK, E_ID;

  always #5 clk_i = ~clk_i;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.master)
  );

  assign obs = {bus.mem_req_o, bus.IorD_o, bus.MemRead_o, bus.MemWrite_o, bus.IRWrite_o,
                bus.PCWrite_o, bus.PCWriteCond_o, bus.BranchNE_o, bus.PCSource_o,
                bus.ALUSrcA_o, bus.ALUSrcB_o, bus.ALU_op_o, bus.RegDst_o, bus.MemtoReg_o,
                bus.RegWrite_o, bus.instr_done_o, bus.fault_o, bus.fault_code_o};

  task automatic drive(input logic [5:0] op, input logic ack);
    @(negedge clk_i);
    bus.instr_op_i = op;
    bus.mem_ack_i  = ack;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    rst_i          = 1'b1;
    bus.mem_ack_i  = 1'b1;
    bus.instr_op_i = 6'b000000;
    #1;
    checks++;
    if (bus.state_o !== 4'd0 || obs !== ctrl_t'('0)) begin
      fails++;
      $display("FAIL reset_hold: state=%0d ctrl=%h, expected state=0 ctrl=%h", bus.state_o, obs, ctrl_t'('0));
    end
    @(negedge clk_i);
    rst_i         = 1'b0;
    bus.mem_ack_i = 1'b0;
    #1;
    checks++;
    if (bus.state_o !== 4'd0 || obs !== E_IF_WAIT) begin
      fails++;
      $display("FAIL reset_release: state=%0d ctrl=%h, expected state=0 ctrl=%h", bus.state_o, obs, E_IF_WAIT);
    end
  endtask

  task automatic test_add();
    ctrl_t       ex [5];
    logic [3:0]  st [5];
    logic        ak [5];
    int unsigned done_cnt = 0;
    ex[0] = E_IF_ACK; st[0] = 4'd0; ak[0] = 1'b1;
    ex[1] = E_ID;     st[1] = 4'd1; ak[1] = 1'b1;
    ex[2] = '0; ex[2].ALUSrcA = 1'b1; ex[2].ALU_op = 3'b100; st[2] = 4'd2; ak[2] = 1'b1;
    ex[3] = '0; ex[3].RegWrite = 1'b1; ex[3].RegDst = 1'b1; ex[3].instr_done = 1'b1;
    st[3] = 4'd8; ak[3] = 1'b0;
    ex[4] = E_IF_WAIT; st[4] = 4'd0; ak[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(6'b000000, ak[i]);
      if (bus.instr_done_o === 1'b1) done_cnt++;
      checks++;
      if (bus.state_o !== st[i] || obs !== ex[i]) begin
        fails++;
        $display("FAIL add[%0d]: state=%0d ctrl=%h, expected state=%0d ctrl=%h", i, bus.state_o, obs, st[i], ex[i]);
      end
    end
    checks++;
    if (done_cnt !== 1) begin
      fails++;
      $display("FAIL add_done_count: got %0d, expected 1", done_cnt);
    end
  endtask

  task automatic test_lw_wait();
    ctrl_t      ex [9];
    logic [3:0] st [9];
    logic       ak [9];
    ex[0] = E_IF_ACK; st[0] = 4'd0; ak[0] = 1'b1;
    ex[1] = E_ID;     st[1] = 4'd1; ak[1] = 1'b0;
    ex[2] = '0; ex[2].ALUSrcA = 1'b1; ex[2].ALUSrcB = 2'b10; st[2] = 4'd5; ak[2] = 1'b0;
    for (int i = 3; i < 7; i++) begin
      ex[i] = '0; ex[i].mem_req = 1'b1; ex[i].MemRead = 1'b1; ex[i].IorD = 1'b1;
      st[i] = 4'd6; ak[i] = (i == 6);
    end
    ex[7] = '0; ex[7].RegWrite = 1'b1; ex[7].MemtoReg = 1'b1; ex[7].instr_done = 1'b1;
    st[7] = 4'd10; ak[7] = 1'b0;
    ex[8] = E_IF_WAIT; st[8] = 4'd0; ak[8] = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(6'b100011, ak[i]);
      checks++;
      if (bus.state_o !== st[i] || obs !== ex[i]) begin
        fails++;
        $display("FAIL lw[%0d]: state=%0d ctrl=%h, expected state=%0d ctrl=%h", i, bus.state_o, obs, st[i], ex[i]);
      end
    end
  endtask

  task automatic test_bne();
    ctrl_t      ex [4];
    logic [3:0] st [4];
    logic       ak [4];
    ex[0] = E_IF_ACK; st[0] = 4'd0; ak[0] = 1'b1;
    ex[1] = E_ID;     st[1] = 4'd1; ak[1] = 1'b0;
    ex[2] = '0; ex[2].ALUSrcA = 1'b1; ex[2].PCWriteCond = 1'b1; ex[2].PCSource = 2'b01;
    ex[2].ALU_op = 3'b101; ex[2].BranchNE = 1'b1; ex[2].instr_done = 1'b1;
    st[2] = 4'd4; ak[2] = 1'b0;
    ex[3] = E_IF_WAIT; st[3] = 4'd0; ak[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(6'b000101, ak[i]);
      checks++;
      if (bus.state_o !== st[i] || obs !== ex[i]) begin
        fails++;
        $display("FAIL bne[%0d]: state=%0d ctrl=%h, expected state=%0d ctrl=%h", i, bus.state_o, obs, st[i], ex[i]);
      end
    end
  endtask

  // beq, ori, lui issued back to back with zero-wait fetches.
  task automatic test_back_to_back();
    ctrl_t      ex [12];
    logic [3:0] st [12];
    logic       ak [12];
    logic [5:0] op [12];
    ex[0] = E_IF_ACK; st[0] = 4'd0; ak[0] = 1'b1; op[0] = 6'b000100;
    ex[1] = E_ID;     st[1] = 4'd1; ak[1] = 1'b0; op[1] = 6'b000100;
    ex[2] = '0; ex[2].ALUSrcA = 1'b1; ex[2].PCWriteCond = 1'b1; ex[2].PCSource = 2'b01;
    ex[2].ALU_op = 3'b001; ex[2].instr_done = 1'b1; st[2] = 4'd4; ak[2] = 1'b0; op[2] = 6'b000100;
    ex[3] = E_IF_ACK; st[3] = 4'd0; ak[3] = 1'b1; op[3] = 6'b001101;
    ex[4] = E_ID;     st[4] = 4'd1; ak[4] = 1'b0; op[4] = 6'b001101;
    ex[5] = '0; ex[5].ALUSrcA = 1'b1; ex[5].ALUSrcB = 2'b10; ex[5].ALU_op = 3'b011;
    st[5] = 4'd3; ak[5] = 1'b0; op[5] = 6'b001101;
    ex[6] = '0; ex[6].RegWrite = 1'b1; ex[6].instr_done = 1'b1;
    st[6] = 4'd9; ak[6] = 1'b0; op[6] = 6'b001101;
    ex[7] = E_IF_ACK; st[7] = 4'd0; ak[7] = 1'b1; op[7] = 6'b001111;
    ex[8] = E_ID;     st[8] = 4'd1; ak[8] = 1'b0; op[8] = 6'b001111;
    ex[9] = '0; ex[9].ALUSrcA = 1'b1; ex[9].ALUSrcB = 2'b10; ex[9].ALU_op = 3'b010;
    st[9] = 4'd3; ak[9] = 1'b0; op[9] = 6'b001111;
    ex[10] = '0; ex[10].RegWrite = 1'b1; ex[10].instr_done = 1'b1;
    st[10] = 4'd9; ak[10] = 1'b0; op[10] = 6'b001111;
    ex[11] = E_IF_WAIT; st[11] = 4'd0; ak[11] = 1'b0; op[11] = 6'b000000;
    for (int i = 0; i < 12; i++) begin
      drive(op[i], ak[i]);
      checks++;
      if (bus.state_o !== st[i] || obs !== ex[i]) begin
        fails++;
        $display("FAIL b2b[%0d]: state=%0d ctrl=%h, expected state=%0d ctrl=%h", i, bus.state_o, obs, st[i], ex[i]);
      end
    end
  endtask

  task automatic test_illegal();
    ctrl_t      ex [6];
    logic [3:0] st [6];
    logic       ak [6];
    logic [5:0] op [6];
    ex[0] = E_IF_ACK; st[0] = 4'd0; ak[0] = 1'b1; op[0] = 6'b111111;
    ex[1] = E_ID;     st[1] = 4'd1; ak[1] = 1'b0; op[1] = 6'b111111;
    for (int i = 2; i < 6; i++) begin
      ex[i] = '0; ex[i].fault = 1'b1; ex[i].fault_code = 2'b01;
      st[i] = 4'd11; ak[i] = 1'b1; op[i] = 6'b000000;
    end
    for (int i = 0; i < 6; i++) begin
      drive(op[i], ak[i]);
      checks++;
      if (bus.state_o !== st[i] || obs !== ex[i]) begin
        fails++;
        $display("FAIL illegal[%0d]: state=%0d ctrl=%h, expected state=%0d ctrl=%h", i, bus.state_o, obs, st[i], ex[i]);
      end
    end
  endtask

  task automatic test_sw_timeout();
    ctrl_t      ex [9];
    logic [3:0] st [9];
    logic       ak [9];
    ex[0] = E_IF_ACK; st[0] = 4'd0; ak[0] = 1'b1;
    ex[1] = E_ID;     st[1] = 4'd1; ak[1] = 1'b0;
    ex[2] = '0; ex[2].ALUSrcA = 1'b1; ex[2].ALUSrcB = 2'b10; st[2] = 4'd5; ak[2] = 1'b0;
    for (int i = 3; i < 7; i++) begin
      ex[i] = '0; ex[i].mem_req = 1'b1; ex[i].MemWrite = 1'b1; ex[i].IorD = 1'b1;
      st[i] = 4'd7; ak[i] = 1'b0;
    end
    for (int i = 7; i < 9; i++) begin
      ex[i] = '0; ex[i].fault = 1'b1; ex[i].fault_code = 2'b10;
      st[i] = 4'd11; ak[i] = 1'b1;
    end
    for (int i = 0; i < 9; i++) begin
      drive(6'b101011, ak[i]);
      checks++;
      if (bus.state_o !== st[i] || obs !== ex[i]) begin
        fails++;
        $display("FAIL sw_timeout[%0d]: state=%0d ctrl=%h, expected state=%0d ctrl=%h", i, bus.state_o, obs, st[i], ex[i]);
      end
    end
  endtask

  task automatic test_sw_ack_last();
    ctrl_t      ex [8];
    logic [3:0] st [8];
    logic       ak [8];
    ex[0] = E_IF_ACK; st[0] = 4'd0; ak[0] = 1'b1;
    ex[1] = E_ID;     st[1] = 4'd1; ak[1] = 1'b0;
    ex[2] = '0; ex[2].ALUSrcA = 1'b1; ex[2].ALUSrcB = 2'b10; st[2] = 4'd5; ak[2] = 1'b0;
    for (int i = 3; i < 7; i++) begin
      ex[i] = '0; ex[i].mem_req = 1'b1; ex[i].MemWrite = 1'b1; ex[i].IorD = 1'b1;
      ex[i].instr_done = (i == 6);
      st[i] = 4'd7; ak[i] = (i == 6);
    end
    ex[7] = E_IF_WAIT; st[7] = 4'd0; ak[7] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(6'b101011, ak[i]);
      checks++;
      if (bus.state_o !== st[i] || obs !== ex[i]) begin
        fails++;
        $display("FAIL sw_ack_last[%0d]: state=%0d ctrl=%h, expected state=%0d ctrl=%h", i, bus.state_o, obs, st[i], ex[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    ctrl_t      ex [4];
    logic [3:0] st [4];
    logic       ak [4];
    ex[0] = E_IF_ACK; st[0] = 4'd0; ak[0] = 1'b1;
    ex[1] = E_ID;     st[1] = 4'd1; ak[1] = 1'b0;
    ex[2] = '0; ex[2].ALUSrcA = 1'b1; ex[2].ALUSrcB = 2'b10; st[2] = 4'd5; ak[2] = 1'b0;
    ex[3] = '0; ex[3].mem_req = 1'b1; ex[3].MemRead = 1'b1; ex[3].IorD = 1'b1;
    st[3] = 4'd6; ak[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(6'b100011, ak[i]);
      checks++;
      if (bus.state_o !== st[i] || obs !== ex[i]) begin
        fails++;
        $display("FAIL reset_mid[%0d]: state=%0d ctrl=%h, expected state=%0d ctrl=%h", i, bus.state_o, obs, st[i], ex[i]);
      end
    end
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (bus.state_o !== 4'd0 || obs !== ctrl_t'('0)) begin
      fails++;
      $display("FAIL reset_mid_async: state=%0d ctrl=%h, expected state=0 ctrl=%h", bus.state_o, obs, ctrl_t'('0));
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checks++;
    if (bus.state_o !== 4'd0 || obs !== E_IF_WAIT) begin
      fails++;
      $display("FAIL reset_mid_release: state=%0d ctrl=%h, expected state=0 ctrl=%h", bus.state_o, obs, E_IF_WAIT);
    end
  endtask

  initial begin
    bus.instr_op_i = 6'b000000;
    bus.mem_ack_i  = 1'b0;
    E_IF_WAIT = '0; E_IF_WAIT.mem_req = 1'b1; E_IF_WAIT.MemRead = 1'b1;
    E_IF_ACK  = E_IF_WAIT; E_IF_ACK.IRWrite = 1'b1; E_IF_ACK.PCWrite = 1'b1;
    E_IF_ACK.ALUSrcB = 2'b01;
    E_ID = '0; E_ID.ALUSrcB = 2'b11;

    test_reset();
    test_add();
    test_lw_wait();
    test_bne();
    test_back_to_back();
    test_illegal();
    test_reset();
    test_sw_timeout();
    test_reset();
    test_sw_ack_last();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
